// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encoding,
// default width and a reference 11011 pattern.
package seq_pattern_tx_pkg;

    localparam int W_DEFAULT = 8;

    // Reference frame 11011 (five bits, so len = 4)
    localparam logic [7:0] PAT_11011 = 8'b0001_1011;
    localparam logic [2:0] LEN_11011 = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_pattern_tx_bit_counter.sv
// Loadable down-counter with a zero flag. Load wins over decrement, and
// decrementing stops at zero so the count never wraps.
module seq_bit_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    assign zero = (count == '0);

    // Reload on request, otherwise count down towards zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends an L-bit pattern MSB first, rep+1 times,
// with a configurable idle gap between frames and a done pulse at the end.
// All request fields are latched at start so later input changes are ignored.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] pattern,
    input  logic [2:0]   len,
    input  logic [3:0]   rep,
    input  logic [1:0]   gap,
    output logic         out,
    output logic         out_valid,
    output logic         busy,
    output logic         done
);

    state_t         state;
    logic [W-1:0]   pat_q;
    logic [2:0]     len_q;
    logic [1:0]     gap_q;
    logic [3:0]     frames_left;

    logic [2:0]     bit_idx;
    logic           bit_zero;
    logic           bit_load;
    logic [2:0]     bit_load_val;
    logic           bit_dec;
    logic [2:0]     idx_dn;

    logic [1:0]     gap_cnt;
    logic           gap_zero;
    logic           gap_load;
    logic [1:0]     gap_load_val;
    logic           gap_dec;

    assign idx_dn = bit_idx - 3'd1;

    // Index of the bit currently on the line
    seq_bit_counter #(.CW(3)) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (bit_load),
        .load_val (bit_load_val),
        .dec      (bit_dec),
        .count    (bit_idx),
        .zero     (bit_zero)
    );

    // Remaining idle cycles between frames
    seq_bit_counter #(.CW(2)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_load_val),
        .dec      (gap_dec),
        .count    (gap_cnt),
        .zero     (gap_zero)
    );

    // Counter steering: reload the bit index at each frame start, run the gap counter in GAP
    always_comb begin
        bit_load     = 1'b0;
        bit_load_val = len_q;
        bit_dec      = 1'b0;
        gap_load     = 1'b0;
        gap_load_val = gap_q - 2'd1;
        gap_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    bit_load     = 1'b1;
                    bit_load_val = len;
                end
            end
            SEND: begin
                if (!abort) begin
                    if (!bit_zero) begin
                        bit_dec = 1'b1;
                    end else if (frames_left != 4'd0) begin
                        if (gap_q == 2'd0) begin
                            bit_load = 1'b1;
                        end else begin
                            gap_load = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (!abort) begin
                    if (gap_zero) begin
                        bit_load = 1'b1;
                    end else begin
                        gap_dec = (gap_cnt != 2'd0);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Transmit FSM with registered outputs; reset beats abort, abort beats start
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            frames_left <= '0;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start && !abort) begin
                        pat_q       <= pattern;
                        len_q       <= len;
                        gap_q       <= gap;
                        frames_left <= rep;
                        out         <= pattern[len];
                        out_valid   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state     <= IDLE;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (!bit_zero) begin
                        out <= pat_q[idx_dn];
                    end else if (frames_left != 4'd0) begin
                        frames_left <= frames_left - 4'd1;
                        if (gap_q == 2'd0) begin
                            out <= pat_q[len_q];
                        end else begin
                            state     <= GAP;
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                        end
                    end else begin
                        state     <= DONE;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gap_zero) begin
                        state     <= SEND;
                        out       <= pat_q[len_q];
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed testbench for seq_pattern_tx. Outputs are sampled on the falling
// edge as the vector {out, out_valid, busy, done}.
module tb_seq_pattern_tx;
    import seq_pattern_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [2:0] len;
    logic [3:0] rep;
    logic [1:0] gap;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int busy_cnt = 0;
    int done_cnt = 0;
    int det_cnt  = 0;
    logic [4:0] sr = '0;
    int base_busy;
    int base_done;
    int base_det;

    seq_pattern_tx #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .len       (len),
        .rep       (rep),
        .gap       (gap),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Loopback monitor: busy/done cycle counts and an 11011 detector on the valid bit stream
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (out_valid) begin
            sr = {sr[3:0], out};
            if (sr == 5'b11011) det_cnt++;
        end else begin
            sr = '0;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expected);
        logic [3:0] observed;
        observed = {out, out_valid, busy, done};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b (out,out_valid,busy,done)", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] p, input logic [2:0] l,
                                 input logic [3:0] r, input logic [1:0] g);
        pattern = p;
        len     = l;
        rep     = r;
        gap     = g;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Check n busy cycles; obits/vbits give out/out_valid, first cycle in bit n-1
    task automatic expectSeq(input string tag, input logic [31:0] obits,
                             input logic [31:0] vbits, input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            checkOutput($sformatf("%s_c%0d", tag, i), {obits[n-1-i], vbits[n-1-i], 2'b10});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; len = '0; rep = '0; gap = '0;
        cyc();
        cyc();
        checkOutput("reset", 4'b0000);

        start = 1'b1; pattern = PAT_11011; len = LEN_11011;
        cyc();
        checkOutput("rst_over_start", 4'b0000);

        $display("[TB] single 11011 frame, started on first edge out of reset");
        base_busy = busy_cnt; base_done = done_cnt; base_det = det_cnt;
        rst = 1'b0;
        applyStimulus(PAT_11011, LEN_11011, 4'd0, 2'd0);
        expectSeq("t1", 32'b11011, 32'b11111, 5);
        cyc(); checkOutput("t1_done", 4'b0011);
        cyc(); checkOutput("t1_idle", 4'b0000);
        checkCount("t1_busy_cycles", busy_cnt - base_busy, 6);
        checkCount("t1_detections", det_cnt - base_det, 1);
        checkCount("t1_done_pulses", done_cnt - base_done, 1);

        $display("[TB] abort and start together in idle");
        abort = 1'b1; start = 1'b1;
        cyc(); checkOutput("abort_beats_start", 4'b0000);
        abort = 1'b0; start = 1'b0;
        cyc(); checkOutput("abort_beats_start_idle", 4'b0000);

        $display("[TB] 101 x3 with gap 2");
        base_busy = busy_cnt;
        applyStimulus(8'b101, 3'd2, 4'd2, 2'd2);
        expectSeq("t2", 32'b1010010100101, 32'b1110011100111, 13);
        cyc(); checkOutput("t2_done", 4'b0011);
        cyc(); checkOutput("t2_idle", 4'b0000);
        checkCount("t2_busy_cycles", busy_cnt - base_busy, 14);

        $display("[TB] A5 x2 back to back");
        base_busy = busy_cnt;
        applyStimulus(8'hA5, 3'd7, 4'd1, 2'd0);
        expectSeq("t3", 32'hA5A5, 32'hFFFF, 16);
        cyc(); checkOutput("t3_done", 4'b0011);
        cyc(); checkOutput("t3_idle", 4'b0000);
        checkCount("t3_busy_cycles", busy_cnt - base_busy, 17);

        $display("[TB] one-bit frames, upper pattern bits ignored");
        base_busy = busy_cnt;
        applyStimulus(8'b1111_1110, 3'd0, 4'd1, 2'd1);
        expectSeq("t_l1", 32'b000, 32'b101, 3);
        cyc(); checkOutput("t_l1_done", 4'b0011);
        cyc(); checkOutput("t_l1_idle", 4'b0000);
        checkCount("t_l1_busy_cycles", busy_cnt - base_busy, 4);

        $display("[TB] abort on third bit of 11011");
        base_done = done_cnt;
        applyStimulus(PAT_11011, LEN_11011, 4'd0, 2'd0);
        cyc(); checkOutput("t4_bit0", 4'b1110);
        cyc(); checkOutput("t4_bit1", 4'b1110);
        cyc(); checkOutput("t4_bit2", 4'b0110);
        abort = 1'b1;
        cyc(); checkOutput("t4_aborted", 4'b0000);
        abort = 1'b0;
        cyc(); checkOutput("t4_still_idle", 4'b0000);
        checkCount("t4_no_done", done_cnt - base_done, 0);

        base_det = det_cnt;
        applyStimulus(PAT_11011, LEN_11011, 4'd0, 2'd0);
        expectSeq("t4_restart", 32'b11011, 32'b11111, 5);
        cyc(); checkOutput("t4_restart_done", 4'b0011);
        cyc(); checkOutput("t4_restart_idle", 4'b0000);
        checkCount("t4_restart_detections", det_cnt - base_det, 1);

        $display("[TB] start while busy, then reset inside the gap");
        applyStimulus(8'b101, 3'd2, 4'd2, 2'd2);
        cyc(); checkOutput("t5_bit0", 4'b1110);
        start = 1'b1; pattern = 8'hFF; len = 3'd7; rep = 4'd0; gap = 2'd0;
        cyc(); checkOutput("t5_bit1_start_ignored", 4'b0110);
        start = 1'b0;
        cyc(); checkOutput("t5_bit2", 4'b1110);
        cyc(); checkOutput("t5_gap", 4'b0010);
        rst = 1'b1;
        cyc(); checkOutput("t5_rst_in_gap", 4'b0000);
        rst = 1'b0;
        cyc(); checkOutput("t5_idle_after_rst", 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
